// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Shares one UART byte transmitter among NREQ requesters. Grants rotate
// round-robin, and a requester may send up to MAX_BURST bytes per grant.
// For each byte the arbiter latches the data, pulses tx_start, waits for
// the transmitter to go busy, and acknowledges the requester. It flags a
// transmitter that never accepts a start within START_TIMEOUT cycles.
// req and tx_busy are registered before the FSM sees them. As a result,
// no output has a combinational path from an input, and every decision
// uses a single consistent snapshot of the inputs.

module uart_tx_arbiter #(
    parameter int NREQ          = 4,
    parameter int MAX_BURST     = 4,
    parameter int START_TIMEOUT = 64
) (
    input  logic                      sysclk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req,
    input  logic [8*NREQ-1:0]         data_in,
    input  logic                      tx_busy,
    output logic                      tx_start,
    output logic [7:0]                tx_data,
    output logic [NREQ-1:0]           ack,
    output logic [$clog2(NREQ)-1:0]   grant_id,
    output logic                      active,
    output logic                      err_timeout
);

    localparam int GW = $clog2(NREQ);
    localparam int TW = $clog2(START_TIMEOUT + 1);

    localparam logic [GW-1:0] LAST_IDX  = GW'(NREQ - 1);
    localparam logic [GW-1:0] ONE_IDX   = GW'(1);
    localparam logic [3:0]    BURST_MAX = 4'(MAX_BURST);
    localparam logic [TW-1:0] T_LIMIT   = TW'(START_TIMEOUT - 1);
    localparam logic [TW-1:0] T_MAX     = '1;
    localparam logic [TW-1:0] T_ONE     = TW'(1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

    state_t            state;
    logic [NREQ-1:0]   req_q;
    logic              busy_q;
    logic [GW-1:0]     ptr;
    logic [3:0]        burst_cnt;
    logic [TW-1:0]     timer;

    logic [7:0]        slice [NREQ];
    logic              sel_valid;
    logic [GW-1:0]     sel_idx;
    logic [GW-1:0]     next_ptr;
    logic [TW-1:0]     timer_inc;

    // Unpack the flat data bus into one byte per requester
    for (genvar g = 0; g < NREQ; g++) begin : g_slice
        assign slice[g] = data_in[8*g +: 8];
    end

    // Round-robin pick: the first requesting index at or after p, wrapping.
    // The loop runs from the far end down, so the closest index is the
    // last one written and therefore wins.
    function automatic logic [GW:0] rr_pick(input logic [NREQ-1:0] r,
                                            input logic [GW-1:0]   p);
        logic [GW:0]   result;
        logic [GW-1:0] idx_v;
        int            idx;
        result = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx   = (int'(p) + k) % NREQ;
            idx_v = idx[GW-1:0];
            if (r[idx_v]) begin
                result = {1'b1, idx_v};
            end
        end
        return result;
    endfunction

    // Combinational helpers: candidate grant, pointer after this grant, saturating timer step
    always_comb begin
        {sel_valid, sel_idx} = rr_pick(req_q, ptr);
        next_ptr  = (grant_id == LAST_IDX) ? '0 : grant_id + ONE_IDX;
        timer_inc = (timer == T_MAX) ? timer : timer + T_ONE;
    end

    assign active = (state != IDLE);

    // Arbitration FSM with input sampling and registered start/ack/error pulses
    always_ff @(posedge sysclk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            req_q       <= '0;
            busy_q      <= 1'b0;
            ptr         <= '0;
            burst_cnt   <= '0;
            timer       <= '0;
            tx_start    <= 1'b0;
            tx_data     <= 8'h00;
            ack         <= '0;
            grant_id    <= '0;
            err_timeout <= 1'b0;
        end else begin
            req_q       <= req;
            busy_q      <= tx_busy;
            tx_start    <= 1'b0;
            ack         <= '0;
            err_timeout <= 1'b0;

            case (state)
                IDLE: begin
                    if (!busy_q && sel_valid) begin
                        tx_data   <= slice[sel_idx];
                        grant_id  <= sel_idx;
                        burst_cnt <= 4'd1;
                        tx_start  <= 1'b1;
                        state     <= START;
                    end
                end

                START: begin
                    timer <= '0;
                    state <= WAIT_BUSY;
                end

                WAIT_BUSY: begin
                    if (busy_q) begin
                        ack[grant_id] <= 1'b1;
                        state         <= WAIT_DONE;
                    end else if (timer_inc == T_LIMIT) begin
                        err_timeout <= 1'b1;
                        ptr         <= next_ptr;
                        burst_cnt   <= '0;
                        state       <= IDLE;
                    end else begin
                        timer <= timer_inc;
                    end
                end

                WAIT_DONE: begin
                    if (!busy_q) begin
                        if (req_q[grant_id] && (burst_cnt < BURST_MAX)) begin
                            tx_data   <= slice[grant_id];
                            burst_cnt <= burst_cnt + 4'd1;
                            tx_start  <= 1'b1;
                            state     <= START;
                        end else begin
                            ptr       <= next_ptr;
                            burst_cnt <= '0;
                            state     <= IDLE;
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
